// File: rtl/onehot_drv_pkg.sv
// Shared types for the one-hot line driver: FSM states and per-command error codes.
package onehot_drv_pkg;

  localparam int WIDTH_DEF   = 4;
  localparam int DEPTH_DEF   = 4;
  localparam int TIMEOUT_DEF = 8;

  typedef enum logic [1:0] {S_IDLE, S_DRIVE, S_GAP} drv_state_t;

  typedef enum logic [1:0] {
    E_NONE     = 2'd0,
    E_MISMATCH = 2'd1,
    E_TIMEOUT  = 2'd2,
    E_RANGE    = 2'd3
  } drv_err_t;

endpackage

// File: rtl/idx_fifo.sv
// Small synchronous FIFO with a fall-through read port so the driver can pop and use
// the head entry in the same cycle; full/empty derive from the pointer wrap bit.
module idx_fifo #(
  parameter int W     = 2,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr_reg, wr_ptr_next;
  logic [AW:0]  rd_ptr_reg, rd_ptr_next;
  logic         do_push, do_pop;

  assign empty   = (wr_ptr_reg == rd_ptr_reg);
  assign full    = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                   (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr_reg[AW-1:0]];

  always_comb begin
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    if (do_push) wr_ptr_next = wr_ptr_reg + (AW+1)'(1);
    if (do_pop)  rd_ptr_next = rd_ptr_reg + (AW+1)'(1);
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_reg[AW-1:0]] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
    end
  end

endmodule

// File: rtl/onehot_line_driver.sv
// Queues line indices, drives each as a one-hot vector, checks the encoder's echo and
// reports done/err per command with a one-cycle idle gap between commands.
module onehot_line_driver
  import onehot_drv_pkg::*;
#(
  parameter int WIDTH   = WIDTH_DEF,
  parameter int IDXW    = $clog2(WIDTH),
  parameter int DEPTH   = DEPTH_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic [IDXW-1:0] cmd_idx,
  output logic [WIDTH-1:0] line,
  input  logic            echo_valid,
  input  logic [IDXW-1:0] echo_pos,
  output logic            busy,
  output logic            done,
  output logic            err,
  output logic [1:0]      err_code
);

  localparam int TW = $clog2(TIMEOUT);
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);

  drv_state_t       state_reg, state_next;
  logic [WIDTH-1:0] line_reg, line_next, dec;
  logic [IDXW-1:0]  idx_reg, idx_next, fifo_dout;
  logic [TW-1:0]    timer_reg, timer_next;
  logic             done_reg, done_next, err_reg, err_next;
  drv_err_t         err_code_reg, err_code_next;
  logic             fifo_pop, fifo_full, fifo_empty;

  assign cmd_ready = !fifo_full;
  assign line      = line_reg;
  assign done      = done_reg;
  assign err       = err_reg;
  assign err_code  = err_code_reg;
  assign busy      = (state_reg != S_IDLE) || !fifo_empty;

  idx_fifo #(.W(IDXW), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (cmd_valid),
    .din   (cmd_idx),
    .pop   (fifo_pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // An index with no matching line decodes to all-zero, which doubles as the range check.
  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_dec
      assign dec[gi] = (fifo_dout == IDXW'(gi));
    end
  endgenerate

  always_comb begin
    state_next    = state_reg;
    line_next     = line_reg;
    idx_next      = idx_reg;
    timer_next    = timer_reg;
    done_next     = 1'b0;
    err_next      = 1'b0;
    err_code_next = E_NONE;
    fifo_pop      = 1'b0;
    case (state_reg)
      S_IDLE: begin
        line_next = '0;
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          if (|dec) begin
            line_next  = dec;
            idx_next   = fifo_dout;
            timer_next = '0;
            state_next = S_DRIVE;
          end else begin
            err_next      = 1'b1;
            err_code_next = E_RANGE;
          end
        end
      end
      S_DRIVE: begin
        // An echo arriving on the final timer cycle is still judged as an echo.
        if (echo_valid) begin
          if (echo_pos == idx_reg) begin
            done_next = 1'b1;
          end else begin
            err_next      = 1'b1;
            err_code_next = E_MISMATCH;
          end
          line_next  = '0;
          state_next = S_GAP;
        end else if (timer_reg == TIMER_LAST) begin
          err_next      = 1'b1;
          err_code_next = E_TIMEOUT;
          line_next     = '0;
          state_next    = S_GAP;
        end else begin
          timer_next = timer_reg + TW'(1);
        end
      end
      S_GAP: begin
        line_next  = '0;
        state_next = S_IDLE;
      end
      default: begin
        line_next  = '0;
        state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= S_IDLE;
      line_reg     <= '0;
      idx_reg      <= '0;
      timer_reg    <= '0;
      done_reg     <= 1'b0;
      err_reg      <= 1'b0;
      err_code_reg <= E_NONE;
    end else begin
      state_reg    <= state_next;
      line_reg     <= line_next;
      idx_reg      <= idx_next;
      timer_reg    <= timer_next;
      done_reg     <= done_next;
      err_reg      <= err_next;
      err_code_reg <= err_code_next;
    end
  end

endmodule

// File: tb/tb_onehot_line_driver.sv
// Directed bench for onehot_line_driver with a scoreboard of expected line vectors and results.
module tb_onehot_line_driver;
  import onehot_drv_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cmd_valid = 1'b0;
  logic [1:0] cmd_idx = 2'd0;
  logic       cmd_ready;
  logic [3:0] line;
  logic       echo_valid;
  logic [1:0] echo_pos;
  logic       busy, done, err;
  logic [1:0] err_code;

  logic       man_valid = 1'b0;
  logic [1:0] man_pos = 2'd0;
  logic       resp_valid = 1'b0;
  logic [1:0] resp_pos = 2'd0;
  bit         resp_en = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;
  int done_cnt = 0;
  logic [3:0] exp_line_q[$];
  logic [1:0] exp_code_q[$];

  assign echo_valid = man_valid | resp_valid;
  assign echo_pos   = man_valid ? man_pos : resp_pos;

  always #5 clk = ~clk;

  onehot_line_driver dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_idx    (cmd_idx),
    .line       (line),
    .echo_valid (echo_valid),
    .echo_pos   (echo_pos),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .err_code   (err_code)
  );

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] enc(input logic [3:0] v);
    logic [1:0] r = 2'd0;
    for (int i = 0; i < 4; i++) if (v[i]) r = 2'(i);
    return r;
  endfunction

  // Accepts one command and records what the DUT should drive and report for it.
  task automatic send(input logic [1:0] idx, input logic [1:0] code);
    int guard = 0;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_idx   = idx;
    while (!cmd_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    check("send_accept_bound", {7'd0, guard < 50}, 8'd1);
    @(posedge clk);
    exp_line_q.push_back(4'b0001 << idx);
    exp_code_q.push_back(code);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic wait_line_on();
    int guard = 0;
    do begin
      @(negedge clk);
      guard++;
    end while (line == 4'b0000 && guard < 30);
    check("line_on_bound", {7'd0, guard < 30}, 8'd1);
  endtask

  // Scoreboard monitor: line rises and result pulses are matched against the queues.
  initial begin
    logic [3:0] prev = 4'b0000;
    logic [1:0] code;
    forever begin
      @(negedge clk);
      check("onehot0", {7'd0, $onehot0(line)}, 8'd1);
      check("done_err_excl", {7'd0, done && err}, 8'd0);
      if (line != 4'b0000 && prev == 4'b0000) begin
        if (exp_line_q.size() == 0) check("line_unexpected", {4'd0, line}, 8'd0);
        else check("line_sb", {4'd0, line}, {4'd0, exp_line_q.pop_front()});
      end
      if (done || err) begin
        code = done ? 2'd0 : err_code;
        if (exp_code_q.size() == 0) check("pulse_unexpected", {6'd0, done, err}, 8'd0);
        else check("result_sb", {6'd0, code}, {6'd0, exp_code_q.pop_front()});
        if (done) done_cnt++;
      end
      prev = line;
    end
  end

  // Encoder model: echoes the driven position on the first cycle the line is seen high.
  initial begin
    bit echoed = 1'b0;
    forever begin
      @(negedge clk);
      if (resp_en && line != 4'b0000 && !echoed) begin
        resp_valid = 1'b1;
        resp_pos   = enc(line);
        echoed     = 1'b1;
      end else begin
        resp_valid = 1'b0;
      end
      if (line == 4'b0000) echoed = 1'b0;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    int base;
    int guard;

    // 1: reset state and a quiet idle period
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_line", {4'd0, line}, 8'd0);
    check("rst_ready", {7'd0, cmd_ready}, 8'd1);
    check("rst_busy", {7'd0, busy}, 8'd0);
    check("rst_pulses", {6'd0, done, err}, 8'd0);
    check("rst_code", {6'd0, err_code}, 8'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("idle_quiet", {line, cmd_ready, busy, done, err}, {4'b0000, 1'b1, 3'b000});
    end

    // 2: matching echo two cycles after the line rises
    send(2'd2, E_NONE);
    @(negedge clk); check("t2_c1_line", {4'd0, line}, 8'd0);
    check("t2_c1_busy", {7'd0, busy}, 8'd1);
    @(negedge clk); check("t2_c2_line", {4'd0, line}, 8'h04);
    @(negedge clk); check("t2_c3_line", {4'd0, line}, 8'h04);
    @(negedge clk); check("t2_c4_line", {4'd0, line}, 8'h04);
    man_valid = 1'b1; man_pos = 2'd2;
    @(negedge clk); man_valid = 1'b0;
    check("t2_done", {6'd0, done, err}, 8'h02);
    check("t2_gap_line", {4'd0, line}, 8'd0);
    @(negedge clk); check("t2_after", {line, done, busy, 2'b00}, 8'd0);

    // 3: wrong position, then echoes outside DRIVE must be ignored
    send(2'd3, E_MISMATCH);
    @(negedge clk);
    @(negedge clk); check("t3_line", {4'd0, line}, 8'h08);
    man_valid = 1'b1; man_pos = 2'd1;
    @(negedge clk); man_pos = 2'd3;
    check("t3_err", {6'd0, done, err}, 8'h01);
    check("t3_code", {6'd0, err_code}, {6'd0, E_MISMATCH});
    check("t3_line_off", {4'd0, line}, 8'd0);
    repeat (3) begin
      @(negedge clk);
      check("t3_stray_echo", {line, 2'b00, done, err}, 8'd0);
    end
    man_valid = 1'b0;

    // 4: no echo -> exactly TIMEOUT cycles high then TIMEOUT error
    send(2'd0, E_TIMEOUT);
    wait_line_on();
    cnt = 0;
    while (line == 4'b0001 && cnt < 20) begin
      cnt++;
      @(negedge clk);
    end
    check("t4_high_cycles", 8'(cnt), 8'd8);
    check("t4_err", {6'd0, done, err}, 8'h01);
    check("t4_code", {6'd0, err_code}, {6'd0, E_TIMEOUT});
    @(negedge clk); check("t4_pulse_len", {6'd0, done, err}, 8'd0);

    // 4b: echo on the last timer cycle beats the timeout
    send(2'd2, E_NONE);
    wait_line_on();
    repeat (7) @(negedge clk);
    check("t4b_still_on", {4'd0, line}, 8'h04);
    man_valid = 1'b1; man_pos = 2'd2;
    @(negedge clk); man_valid = 1'b0;
    check("t4b_echo_wins", {6'd0, done, err}, 8'h02);
    repeat (2) @(negedge clk);

    // 5: back-to-back pushes fill the FIFO; echoes start once it is full
    base = done_cnt;
    send(2'd0, E_NONE);
    send(2'd1, E_NONE);
    send(2'd2, E_NONE);
    send(2'd3, E_NONE);
    send(2'd1, E_NONE);
    @(negedge clk);
    check("t5_full_ready", {7'd0, cmd_ready}, 8'd0);
    check("t5_busy", {7'd0, busy}, 8'd1);
    check("t5_first_line", {4'd0, line}, 8'h01);
    resp_en = 1'b1;
    guard = 0;
    while (!cmd_ready && guard < 30) begin
      @(negedge clk);
      guard++;
    end
    check("t5_ready_returns", {7'd0, cmd_ready}, 8'd1);
    guard = 0;
    while (done_cnt < base + 5 && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    check("t5_done_count", 8'(done_cnt - base), 8'd5);
    resp_en = 1'b0;
    repeat (3) @(negedge clk);
    check("t5_line_q_empty", 8'(exp_line_q.size()), 8'd0);
    check("t5_code_q_empty", 8'(exp_code_q.size()), 8'd0);

    // 6: asynchronous reset mid-DRIVE with two commands queued
    send(2'd1, E_NONE);
    send(2'd2, E_NONE);
    send(2'd3, E_NONE);
    @(negedge clk);
    check("t6_driving", {4'd0, line}, 8'h02);
    #2 rst_n = 1'b0;
    #1;
    check("t6_async_line", {4'd0, line}, 8'd0);
    check("t6_async_ready", {7'd0, cmd_ready}, 8'd1);
    check("t6_async_busy", {7'd0, busy}, 8'd0);
    exp_line_q.delete();
    exp_code_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("t6_after_reset", {line, cmd_ready, busy, done, err}, {4'b0000, 1'b1, 3'b000});
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
